// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder: FSM encoding,
// transfer-type constants, default sizing and byte-lane helpers.
package memory_responder_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 8;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic WB_WORD  = 1'b1;
    localparam logic WB_BYTE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [3:0] lane_mask(input logic word_byte, input logic [1:0] lane);
        if (word_byte == WB_WORD) begin
            return 4'b1111;
        end
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Initiator/responder bus for the four-phase MFA/MFC memory handshake.
interface memory_responder_if
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  MFA;
    logic                  READ_WRITE;
    logic                  WORD_BYTE;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           DataIn;
    logic [31:0]           DataOut;
    logic                  MFC;
    logic                  Busy;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        input  DataOut, MFC, Busy
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        output DataOut, MFC, Busy
    );
endinterface

// File: rtl/memory_responder_mem_byte_array.sv
// Word-organised byte-lane storage: four independent 8-bit lanes with
// per-lane write enables and a registered read port.
module mem_byte_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-3:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Read-before-write on a shared port keeps each lane a plain single-port RAM.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we[i]) begin
                    mem[addr] <= wdata[8*i +: 8];
                end
                rd_q <= mem[addr];
            end
        end
    end

    assign rdata = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};

endmodule

// File: rtl/memory_responder.sv
// Four-phase MFA/MFC memory responder: captures a request, waits a fixed
// number of cycles, performs a byte or word access and holds MFC until MFA drops.
//
// state     | meaning
// ST_IDLE   | no transaction; MFA=1 captures a new request
// ST_WAIT   | counting down WAIT_CYCLES; MFA=0 aborts with no write
// ST_ACCESS | two cycles: issue array op, then register DataOut and raise MFC
// ST_DONE   | MFC held high until MFA is seen low
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset,
    memory_responder_if.slave bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  access_phase;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rw_q;
    logic                  wb_q;
    logic [31:0]           data_q;
    logic                  mfc_q;
    logic                  busy_q;
    logic [31:0]           data_out_q;

    logic                  mem_en;
    logic [3:0]            lane_we;
    logic [31:0]           lane_wdata;
    logic [31:0]           rd_word;

    // The array op is issued only in the first ACCESS cycle, from latched values.
    always_comb begin
        mem_en     = (state == ST_ACCESS) && !access_phase;
        lane_we    = 4'b0000;
        lane_wdata = (wb_q == WB_WORD) ? data_q : {4{data_q[7:0]}};
        if (mem_en && (rw_q == RW_WRITE)) begin
            lane_we = lane_mask(wb_q, addr_q[1:0]);
        end
    end

    mem_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (Clk),
        .en    (mem_en),
        .we    (lane_we),
        .addr  (addr_q[ADDR_WIDTH-1:2]),
        .wdata (lane_wdata),
        .rdata (rd_word)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            access_phase <= 1'b0;
            mfc_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_out_q   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.MFA) begin
                        addr_q <= bus.Address;
                        rw_q   <= bus.READ_WRITE;
                        wb_q   <= bus.WORD_BYTE;
                        data_q <= bus.DataIn;
                        busy_q <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.MFA) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt <= 4'd1) begin
                        state    <= ST_ACCESS;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!access_phase) begin
                        access_phase <= 1'b1;
                    end else begin
                        access_phase <= 1'b0;
                        state        <= ST_DONE;
                        mfc_q        <= 1'b1;
                        if (rw_q == RW_READ) begin
                            data_out_q <= (wb_q == WB_WORD) ? rd_word
                                        : {24'h0, lane_byte(rd_word, addr_q[1:0])};
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.MFA) begin
                        state  <= ST_IDLE;
                        mfc_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.MFC     = mfc_q;
    assign bus.Busy    = busy_q;
    assign bus.DataOut = data_out_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: table of handshake transactions on a
// WAIT_CYCLES=2 build plus hand sequences for abort, reset and a zero-wait build.
module tb_memory_responder;
    import memory_responder_pkg::*;

    logic Clk = 1'b0;
    logic reset_a;
    logic reset_b;

    memory_responder_if #(.ADDR_WIDTH(8)) ifa ();
    memory_responder_if #(.ADDR_WIDTH(8)) ifb ();

    memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
        .Clk   (Clk),
        .Reset (reset_a),
        .bus   (ifa.slave)
    );

    memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .Clk   (Clk),
        .Reset (reset_b),
        .bus   (ifb.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw;
        logic        wb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        int          hold;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int sel, input logic mfa, input logic rw, input logic wb,
                           input logic [7:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            ifa.MFA = mfa; ifa.READ_WRITE = rw; ifa.WORD_BYTE = wb;
            ifa.Address = addr; ifa.DataIn = data;
        end else begin
            ifb.MFA = mfa; ifb.READ_WRITE = rw; ifb.WORD_BYTE = wb;
            ifb.Address = addr; ifb.DataIn = data;
        end
    endtask

    task automatic set_mfa(input int sel, input logic v);
        if (sel == 0) ifa.MFA = v;
        else          ifb.MFA = v;
    endtask

    function automatic logic get_mfc(input int sel);
        return (sel == 0) ? ifa.MFC : ifb.MFC;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? ifa.Busy : ifb.Busy;
    endfunction

    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 0) ? ifa.DataOut : ifb.DataOut;
    endfunction

    // MFA must already be high with the DUT idle; the next edge is the capture edge.
    task automatic finish_txn(input int sel, input string name, input int exp_lat,
                              input logic [31:0] exp_dout, input int hold);
        int          lat;
        logic [31:0] d0;
        logic [31:0] r;
        bit          stable;
        lat    = 0;
        stable = 1'b1;
        tick();
        r = $urandom();
        set_req(sel, 1'b1, r[0], r[1], r[15:8], $urandom());
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (get_mfc(sel)) begin
                lat = n;
                break;
            end
        end
        check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            check($sformatf("%s dataout", name), get_dout(sel), exp_dout);
            check($sformatf("%s busy in done", name), 32'(get_busy(sel)), 32'd1);
            d0 = get_dout(sel);
            for (int h = 0; h < hold; h++) begin
                tick();
                if (!get_mfc(sel) || get_dout(sel) !== d0) stable = 1'b0;
            end
            if (hold > 0) check($sformatf("%s hold stable", name), 32'(stable), 32'd1);
        end
        set_mfa(sel, 1'b0);
        tick();
        check($sformatf("%s mfc release", name), 32'(get_mfc(sel)), 32'd0);
        check($sformatf("%s busy release", name), 32'(get_busy(sel)), 32'd0);
    endtask

    task automatic do_txn(input int sel, input string name, input logic rw, input logic wb,
                          input logic [7:0] addr, input logic [31:0] data, input int exp_lat,
                          input logic [31:0] exp_dout, input int hold);
        set_req(sel, 1'b1, rw, wb, addr, data);
        finish_txn(sel, name, exp_lat, exp_dout, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs[0]  = '{RW_WRITE, WB_WORD, 8'h10, 32'hDEADBEEF, 32'h00000000, 0};
        vecs[1]  = '{RW_READ,  WB_WORD, 8'h10, 32'h00000000, 32'hDEADBEEF, 5};
        vecs[2]  = '{RW_READ,  WB_BYTE, 8'h11, 32'h00000000, 32'h000000BE, 0};
        vecs[3]  = '{RW_WRITE, WB_BYTE, 8'h12, 32'hFFFFFF5A, 32'h000000BE, 0};
        vecs[4]  = '{RW_READ,  WB_WORD, 8'h10, 32'h00000000, 32'hDE5ABEEF, 0};
        vecs[5]  = '{RW_READ,  WB_BYTE, 8'h13, 32'h00000000, 32'h000000DE, 0};
        vecs[6]  = '{RW_WRITE, WB_WORD, 8'h20, 32'hAABBCCDD, 32'h000000DE, 2};
        vecs[7]  = '{RW_READ,  WB_WORD, 8'h22, 32'h00000000, 32'hAABBCCDD, 0};
        vecs[8]  = '{RW_WRITE, WB_BYTE, 8'h21, 32'h00000011, 32'hAABBCCDD, 0};
        vecs[9]  = '{RW_READ,  WB_WORD, 8'h20, 32'h00000000, 32'hAABB11DD, 0};
        vecs[10] = '{RW_WRITE, WB_WORD, 8'h30, 32'h01020304, 32'hAABB11DD, 0};
        vecs[11] = '{RW_READ,  WB_BYTE, 8'h30, 32'h00000000, 32'h00000004, 0};

        reset_a = 1'b1;
        reset_b = 1'b1;
        set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset mfc %0d", s), 32'(get_mfc(s)), 32'd0);
            check($sformatf("reset busy %0d", s), 32'(get_busy(s)), 32'd0);
            check($sformatf("reset dataout %0d", s), get_dout(s), 32'h0);
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            do_txn(0, $sformatf("vec%0d", i), vecs[i].rw, vecs[i].wb, vecs[i].addr,
                   vecs[i].data, 4, vecs[i].exp_dout, vecs[i].hold);
        end

        // MFA withdrawn during WAIT: no MFC, no write.
        set_req(0, 1'b1, RW_WRITE, WB_WORD, 8'h20, 32'h12345678);
        tick();
        set_mfa(0, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (get_mfc(0)) seen = 1'b1;
        end
        check("abort mfc never high", 32'(seen), 32'd0);
        check("abort busy", 32'(get_busy(0)), 32'd0);
        do_txn(0, "abort readback", RW_READ, WB_WORD, 8'h20, 32'h0, 4, 32'hAABB11DD, 0);

        // Reset during WAIT drops the pending write.
        set_req(0, 1'b1, RW_WRITE, WB_WORD, 8'h30, 32'hCAFEF00D);
        tick();
        reset_a = 1'b1;
        set_mfa(0, 1'b0);
        tick();
        check("reset in wait busy", 32'(get_busy(0)), 32'd0);
        reset_a = 1'b0;
        tick();
        do_txn(0, "reset wait readback", RW_READ, WB_WORD, 8'h30, 32'h0, 4, 32'h01020304, 0);

        // Reset in DONE, then MFA already high as reset releases.
        set_req(0, 1'b1, RW_READ, WB_WORD, 8'h10, 32'h0);
        tick();
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (get_mfc(0)) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach done before reset", 32'(seen), 32'd1);
        reset_a = 1'b1;
        tick();
        check("reset in done mfc", 32'(get_mfc(0)), 32'd0);
        check("reset in done dataout", get_dout(0), 32'h0);
        check("reset in done busy", 32'(get_busy(0)), 32'd0);
        set_req(0, 1'b1, RW_READ, WB_WORD, 8'h10, 32'h0);
        tick();
        reset_a = 1'b0;
        finish_txn(0, "post reset request", 4, 32'hDE5ABEEF, 0);

        // Zero-wait build.
        do_txn(1, "nowait write", RW_WRITE, WB_WORD, 8'h10, 32'h11223344, 2, 32'h0, 0);
        do_txn(1, "nowait unaligned read", RW_READ, WB_WORD, 8'h13, 32'h0, 2, 32'h11223344, 1);
        do_txn(1, "nowait byte read", RW_READ, WB_BYTE, 8'h12, 32'h0, 2, 32'h00000022, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
